// File: rtl/doorlock_pkg.sv
// Shared definitions for the door-lock controller: one-hot state encoding
// and a small index encoder used by the switch decoder.
package doorlock_pkg;

    localparam int STATE_W = 8;
    localparam int IDX_W   = 5;

    // The encoding is the state output itself; b7:6 stay zero.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 8'h01,
        ST_ENTER   = 8'h02,
        ST_OK      = 8'h04,
        ST_FAIL    = 8'h08,
        ST_LOCKOUT = 8'h10,
        ST_PROG    = 8'h20
    } state_e;

    // Index of the highest set bit. The caller decides separately whether
    // the vector was truly one-hot.
    function automatic logic [IDX_W-1:0] onehot_index(input logic [31:0] v);
        onehot_index = '0;
        for (int i = 0; i < 32; i++)
            if (v[i]) onehot_index = IDX_W'(i);
    endfunction

endpackage

// File: rtl/doorlock_ctrl_sw_digit_decoder.sv
// Turns switch rising edges into digit events. More than one simultaneous
// rise is reported as an event carrying an invalid digit.
import doorlock_pkg::*;

module sw_digit_decoder #(
    parameter int SW_W  = 8,
    parameter int DIG_W = $clog2(SW_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SW_W-1:0]  sw,
    output logic             evt,
    output logic             valid,
    output logic [DIG_W-1:0] digit
);

    logic [SW_W-1:0] sw_q;
    logic [SW_W-1:0] rise;

    always_ff @(posedge clk) begin
        if (rst) sw_q <= '0;
        else     sw_q <= sw;
    end

    assign rise  = sw & ~sw_q;
    assign evt   = |rise;
    assign valid = evt && ((rise & (rise - 1'b1)) == '0);
    assign digit = DIG_W'(onehot_index(32'(rise)));

endmodule

// File: rtl/doorlock_ctrl.sv
// N-digit door-lock controller with a reprogrammable code, a retry limit
// and a timed lockout. All outputs come straight from registers.
import doorlock_pkg::*;

module doorlock_ctrl #(
    parameter int N_DIGITS      = 3,
    parameter int SW_W          = 8,
    parameter logic [N_DIGITS*$clog2(SW_W)-1:0] DEFAULT_CODE = 9'h190,
    parameter int MAX_TRIES     = 3,
    parameter int OPEN_CYCLES   = 16,
    parameter int LOCK_CYCLES   = 64,
    parameter int ENTRY_TIMEOUT = 256
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [SW_W-1:0]                 sw,
    input  logic                            btn_start,
    input  logic                            btn_end,
    input  logic                            btn_prog,
    input  logic                            enable,
    output logic [7:0]                      state,
    output logic [$clog2(N_DIGITS+2)-1:0]   digit_cnt,
    output logic                            unlocked,
    output logic [$clog2(MAX_TRIES+1)-1:0]  tries_left,
    output logic                            code_saved
);

    localparam int DIG_W   = $clog2(SW_W);
    localparam int CNT_W   = $clog2(N_DIGITS+2);
    localparam int TRY_W   = $clog2(MAX_TRIES+1);
    localparam int TMR_MAX = (OPEN_CYCLES > LOCK_CYCLES)
                           ? ((OPEN_CYCLES > ENTRY_TIMEOUT) ? OPEN_CYCLES : ENTRY_TIMEOUT)
                           : ((LOCK_CYCLES > ENTRY_TIMEOUT) ? LOCK_CYCLES : ENTRY_TIMEOUT);
    localparam int TMR_W   = $clog2(TMR_MAX+1);

    // Reload values are one less than the dwell so the state is visible
    // for exactly the configured number of cycles.
    localparam logic [TMR_W-1:0] T_OPEN  = TMR_W'(OPEN_CYCLES-1);
    localparam logic [TMR_W-1:0] T_LOCK  = TMR_W'(LOCK_CYCLES-1);
    localparam logic [TMR_W-1:0] T_ENTRY = TMR_W'(ENTRY_TIMEOUT-1);
    localparam logic [CNT_W-1:0] CNT_N   = CNT_W'(N_DIGITS);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(N_DIGITS+1);
    localparam logic [TRY_W-1:0] TRY_MAX = TRY_W'(MAX_TRIES);

    state_e                          state_q;
    logic [N_DIGITS-1:0][DIG_W-1:0]  code_q;
    logic [N_DIGITS-1:0][DIG_W-1:0]  shadow_q;
    logic                            err_q;
    logic [TMR_W-1:0]                timer;
    logic                            evt, valid;
    logic [DIG_W-1:0]                digit;
    logic [DIG_W-1:0]                exp_digit;
    logic [CNT_W-1:0]                cnt_inc;

    sw_digit_decoder #(.SW_W(SW_W), .DIG_W(DIG_W)) u_dec (
        .clk   (clk),
        .rst   (rst),
        .sw    (sw),
        .evt   (evt),
        .valid (valid),
        .digit (digit)
    );

    always_comb begin
        exp_digit = '0;
        for (int i = 0; i < N_DIGITS; i++)
            if (digit_cnt == CNT_W'(i)) exp_digit = code_q[i];
    end

    assign cnt_inc = (digit_cnt == CNT_SAT) ? digit_cnt : digit_cnt + 1'b1;
    assign state   = state_q;

    // tries_left is kept directly as MAX_TRIES minus the failure count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            digit_cnt  <= '0;
            unlocked   <= 1'b0;
            tries_left <= TRY_MAX;
            code_saved <= 1'b0;
            code_q     <= DEFAULT_CODE;
            shadow_q   <= '0;
            err_q      <= 1'b0;
            timer      <= '0;
        end else begin
            code_saved <= 1'b0;
            unlocked   <= 1'b0;
            if (state_q == ST_LOCKOUT) begin
                if (timer == '0) begin
                    state_q    <= ST_IDLE;
                    digit_cnt  <= '0;
                    tries_left <= TRY_MAX;
                end else begin
                    timer <= timer - 1'b1;
                end
            end else if (enable) begin
                state_q   <= ST_IDLE;
                digit_cnt <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (btn_start) begin
                            state_q   <= ST_ENTER;
                            digit_cnt <= '0;
                            err_q     <= 1'b0;
                            timer     <= T_ENTRY;
                        end
                    end
                    ST_ENTER: begin
                        if (btn_end) begin
                            if (!err_q && digit_cnt == CNT_N) begin
                                state_q    <= ST_OK;
                                unlocked   <= 1'b1;
                                tries_left <= TRY_MAX;
                                timer      <= T_OPEN;
                            end else if (tries_left == TRY_W'(1)) begin
                                state_q    <= ST_LOCKOUT;
                                tries_left <= '0;
                                timer      <= T_LOCK;
                            end else begin
                                state_q    <= ST_FAIL;
                                tries_left <= tries_left - 1'b1;
                                timer      <= T_OPEN;
                            end
                        end else if (evt) begin
                            digit_cnt <= cnt_inc;
                            timer     <= T_ENTRY;
                            if (!valid || digit_cnt >= CNT_N || digit != exp_digit)
                                err_q <= 1'b1;
                        end else if (timer == '0) begin
                            state_q   <= ST_IDLE;
                            digit_cnt <= '0;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                    ST_OK: begin
                        if (btn_prog) begin
                            state_q   <= ST_PROG;
                            digit_cnt <= '0;
                            err_q     <= 1'b0;
                            timer     <= T_ENTRY;
                        end else if (timer == '0) begin
                            state_q   <= ST_IDLE;
                            digit_cnt <= '0;
                        end else begin
                            timer    <= timer - 1'b1;
                            unlocked <= 1'b1;
                        end
                    end
                    ST_FAIL: begin
                        if (timer == '0) begin
                            state_q   <= ST_IDLE;
                            digit_cnt <= '0;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                    ST_PROG: begin
                        if (btn_end) begin
                            if (!err_q && digit_cnt == CNT_N) begin
                                code_q     <= shadow_q;
                                code_saved <= 1'b1;
                            end
                            state_q   <= ST_IDLE;
                            digit_cnt <= '0;
                        end else if (evt) begin
                            digit_cnt <= cnt_inc;
                            timer     <= T_ENTRY;
                            if (!valid || digit_cnt >= CNT_N)
                                err_q <= 1'b1;
                            else
                                for (int i = 0; i < N_DIGITS; i++)
                                    if (digit_cnt == CNT_W'(i)) shadow_q[i] <= digit;
                        end else if (timer == '0) begin
                            state_q   <= ST_IDLE;
                            digit_cnt <= '0;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        digit_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_doorlock_ctrl.sv
// Directed bench for doorlock_ctrl: inputs change and outputs are sampled
// on the falling edge, half a cycle away from the active edge.
module tb_doorlock_ctrl;

    localparam logic [7:0] S_IDLE  = 8'h01;
    localparam logic [7:0] S_ENTER = 8'h02;
    localparam logic [7:0] S_OK    = 8'h04;
    localparam logic [7:0] S_FAIL  = 8'h08;
    localparam logic [7:0] S_LOCK  = 8'h10;
    localparam logic [7:0] S_PROG  = 8'h20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sw = '0;
    logic       btn_start = 1'b0, btn_end = 1'b0, btn_prog = 1'b0, enable = 1'b0;
    logic [7:0] state;
    logic [2:0] digit_cnt;
    logic       unlocked;
    logic [1:0] tries_left;
    logic       code_saved;

    int n_vec = 0;
    int n_err = 0;

    doorlock_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .sw         (sw),
        .btn_start  (btn_start),
        .btn_end    (btn_end),
        .btn_prog   (btn_prog),
        .enable     (enable),
        .state      (state),
        .digit_cnt  (digit_cnt),
        .unlocked   (unlocked),
        .tries_left (tries_left),
        .code_saved (code_saved)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_start();
        btn_start = 1'b1; step(1); btn_start = 1'b0;
    endtask

    task automatic press_end();
        btn_end = 1'b1; step(1); btn_end = 1'b0;
    endtask

    task automatic press_prog();
        btn_prog = 1'b1; step(1); btn_prog = 1'b0;
    endtask

    task automatic dig(input int d);
        sw = 8'h01 << d; step(1);
        sw = '0;         step(1);
    endtask

    task automatic enter3(input int a, input int b, input int c);
        press_start(); dig(a); dig(b); dig(c); press_end();
    endtask

    initial begin
        step(2);
        rst = 1'b0;
        step(1);
        chk("rst_state", state, S_IDLE);
        chk("rst_cnt", digit_cnt, 0);
        chk("rst_unlocked", unlocked, 0);
        chk("rst_tries", tries_left, 3);
        chk("rst_saved", code_saved, 0);

        // default code unlocks for exactly 16 cycles
        press_start();
        chk("start_enter", state, S_ENTER);
        dig(0); dig(2); dig(6);
        chk("cnt3", digit_cnt, 3);
        press_end();
        chk("ok_state", state, S_OK);
        chk("ok_unlocked", unlocked, 1);
        step(15);
        chk("ok_last", state, S_OK);
        chk("ok_last_unl", unlocked, 1);
        step(1);
        chk("ok_exit", state, S_IDLE);
        chk("ok_exit_unl", unlocked, 0);
        chk("ok_tries", tries_left, 3);

        // three wrong entries lead to lockout
        enter3(0, 2, 5);
        chk("fail1_state", state, S_FAIL);
        chk("fail1_tries", tries_left, 2);
        step(16);
        chk("fail1_exit", state, S_IDLE);
        enter3(0, 2, 5);
        chk("fail2_tries", tries_left, 1);
        step(16);
        enter3(0, 2, 5);
        chk("lock_state", state, S_LOCK);
        chk("lock_tries", tries_left, 0);
        enable = 1'b1; btn_start = 1'b1; step(1);
        enable = 1'b0; btn_start = 1'b0;
        chk("lock_hold_en", state, S_LOCK);
        step(62);
        chk("lock_last", state, S_LOCK);
        step(1);
        chk("lock_exit", state, S_IDLE);
        chk("lock_exit_tries", tries_left, 3);

        // multi-hot digit poisons the entry
        press_start();
        sw = 8'h05; step(1); sw = '0; step(1);
        dig(2); dig(6);
        chk("multi_cnt", digit_cnt, 3);
        press_end();
        chk("multi_fail", state, S_FAIL);
        chk("multi_tries", tries_left, 2);
        step(16);

        // a fourth digit overflows the entry
        press_start(); dig(0); dig(2); dig(6); dig(1);
        chk("ovf_cnt", digit_cnt, 4);
        press_end();
        chk("ovf_fail", state, S_FAIL);
        chk("ovf_tries", tries_left, 1);
        step(16);

        // reprogram to 7,1,3
        enter3(0, 2, 6);
        chk("pre_prog_ok", state, S_OK);
        chk("pre_prog_tries", tries_left, 3);
        press_prog();
        chk("prog_state", state, S_PROG);
        chk("prog_cnt", digit_cnt, 0);
        dig(7); dig(1); dig(3);
        press_end();
        chk("prog_idle", state, S_IDLE);
        chk("prog_saved", code_saved, 1);
        step(1);
        chk("prog_saved_pulse", code_saved, 0);
        enter3(0, 2, 6);
        chk("old_code_fails", state, S_FAIL);
        step(16);
        enter3(7, 1, 3);
        chk("new_code_ok", state, S_OK);
        chk("new_code_tries", tries_left, 3);
        step(16);

        // short reprogram leaves the code unchanged
        enter3(7, 1, 3);
        press_prog();
        dig(5); dig(5);
        press_end();
        chk("short_prog_idle", state, S_IDLE);
        chk("short_prog_saved", code_saved, 0);
        enter3(7, 1, 3);
        chk("short_prog_keep", state, S_OK);
        step(16);

        // idle timeout in ENTER counts no failure
        press_start();
        step(255);
        chk("tmo_last", state, S_ENTER);
        step(1);
        chk("tmo_idle", state, S_IDLE);
        chk("tmo_tries", tries_left, 3);

        // enable aborts an entry
        press_start(); dig(7); dig(1);
        chk("en_cnt2", digit_cnt, 2);
        enable = 1'b1; step(1); enable = 1'b0;
        chk("en_idle", state, S_IDLE);
        chk("en_cnt0", digit_cnt, 0);

        // held switch counts once; digit coincident with end is dropped
        press_start();
        sw = 8'h80; step(3); sw = '0; step(1);
        chk("held_cnt", digit_cnt, 1);
        dig(1);
        sw = 8'h08; btn_end = 1'b1; step(1);
        sw = '0; btn_end = 1'b0;
        chk("coinc_fail", state, S_FAIL);
        chk("coinc_cnt", digit_cnt, 2);
        chk("coinc_tries", tries_left, 2);
        step(17);

        // reset mid-entry restores the default code and tries
        press_start(); dig(7);
        rst = 1'b1; step(1); rst = 1'b0;
        chk("rst2_state", state, S_IDLE);
        chk("rst2_tries", tries_left, 3);
        enter3(0, 2, 6);
        chk("rst2_default_ok", state, S_OK);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
